y86_fetch_queue: RTL and testbench

Parametrised Y86-64 fetch stage with a decoupling instruction queue between fetch and decode. Each cycle it predecodes one instruction from byte-addressed instruction memory at the fetch PC, pushes the fields plus status into a QDEPTH-entry FIFO, and predicts the next PC. Decode drains the FIFO with a valid/ready handshake. The execute/writeback stages redirect fetch on mispredict or `ret`.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_predecode.sv | 40 ++++
 rtl/y86_fetch_queue.sv | 89 ++++++++
 tb/tb_y86_fetch_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes, fetch-entry type and instruction lengths
package y86_pkg;
  typedef enum logic [2:0] {
    S_NONE = 3'd0,
    S_AOK  = 3'd1,
    S_HLT  = 3'd2,
    S_ADR  = 3'd3,
    S_INS  = 3'd4
  } stat_t;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] pc;
    stat_t       stat;
  } fetch_entry_t;
  function automatic logic [3:0] inst_len(input logic [3:0] icode);
    return (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) ? 4'd10 :
           (icode inside {I_JXX, I_CALL}) ? 4'd9 :
           (icode inside {I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ}) ? 4'd2 : 4'd1;
  endfunction
endpackage

// File: rtl/y86_predecode.sv
// y86_predecode: field extraction, length, status and next-PC prediction; FETCH_BRANCH_PREDICT_EN predicts all jXX taken
module y86_predecode
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 2048
) (
  input  logic [63:0]  pc,
  input  logic [79:0]  raw,
  output fetch_entry_t ent,
  output logic [63:0]  next_pc
);
  logic [3:0] icode, ifun, len;
  logic       pc_bad, adr, ins, jmp_taken;
`ifdef FETCH_BRANCH_PREDICT_EN
  assign jmp_taken = 1'b1;
`else
  assign jmp_taken = (ifun == 4'h0);
`endif
  // raw holds the ten bytes at pc with byte 0 in the top bits, so valC is big-endian as stored
  always_comb begin
    pc_bad     = pc >= 64'(IMEM_BYTES);
    icode      = pc_bad ? 4'h0 : raw[79:76];
    ifun       = pc_bad ? 4'h0 : raw[75:72];
    len        = pc_bad ? 4'd1 : inst_len(icode);
    adr        = pc_bad || (pc + 64'(len) - 64'd1 >= 64'(IMEM_BYTES));
    ins        = (icode > I_POPQ) ||
                 ((icode == I_RRMOVQ || icode == I_JXX) ? ifun > 4'd6 :
                  (icode == I_OPQ) ? ifun > 4'd3 : ifun != 4'd0);
    ent.icode  = icode;
    ent.ifun   = ifun;
    ent.rA     = (icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ}) ? raw[71:68] : 4'hF;
    ent.rB     = (icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ}) ? raw[67:64] : 4'hF;
    ent.valC   = (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) ? raw[63:0] :
                 (icode inside {I_JXX, I_CALL}) ? raw[71:8] : 64'h0;
    ent.valP   = pc + 64'(len);
    ent.pc     = pc;
    ent.stat   = adr ? S_ADR : ins ? S_INS : (icode == I_HALT) ? S_HLT : S_AOK;
    next_pc    = (icode == I_CALL || (icode == I_JXX && jmp_taken)) ? ent.valC : ent.valP;
  end
endmodule

// File: rtl/y86_fetch_queue.sv
// y86_fetch_queue: Y86-64 fetch stage with imem, fetch PC, stop flags and a decode-side FIFO; FETCH_BRANCH_PREDICT_EN selects jXX prediction
module y86_fetch_queue
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 2048,
  parameter int          QDEPTH     = 4,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      imem_we,
  input  logic [63:0]               imem_waddr,
  input  logic [7:0]                imem_wdata,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  input  logic                      d_ready,
  output logic                      d_valid,
  output logic [3:0]                d_icode,
  output logic [3:0]                d_ifun,
  output logic [3:0]                d_rA,
  output logic [3:0]                d_rB,
  output logic [63:0]               d_valC,
  output logic [63:0]               d_valP,
  output logic [63:0]               d_pc,
  output logic [2:0]                d_stat,
  output logic [$clog2(QDEPTH):0]   q_count
);
  localparam int AW = $clog2(IMEM_BYTES);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  logic [7:0]    mem [IMEM_BYTES];
  fetch_entry_t  q [QDEPTH];
  fetch_entry_t  ent, hd;
  logic [63:0]   fpc, next_pc;
  logic [79:0]   raw;
  logic [PW-1:0] head, tail;
  logic          halted, ret_wait, fetch, pop, stop;
  // gather the ten bytes at fpc; bytes past the end of memory read as zero
  always_comb begin
    raw = '0;
    for (int i = 0; i < 10; i++)
      raw[79-8*i -: 8] = (fpc + 64'(i) < 64'(IMEM_BYTES)) ? mem[AW'(fpc + 64'(i))] : 8'h0;
  end
  y86_predecode #(.IMEM_BYTES(IMEM_BYTES)) u_pd (.pc(fpc), .raw(raw), .ent(ent), .next_pc(next_pc));
  assign hd      = q[head];
  assign d_valid = (q_count != '0) && !redirect_valid;
  assign d_icode = hd.icode;
  assign d_ifun  = hd.ifun;
  assign d_rA    = hd.rA;
  assign d_rB    = hd.rB;
  assign d_valC  = hd.valC;
  assign d_valP  = hd.valP;
  assign d_pc    = hd.pc;
  assign d_stat  = hd.stat;
  assign fetch   = (q_count < CW'(QDEPTH)) && !halted && !ret_wait && !redirect_valid;
  assign pop     = d_valid && d_ready;
  assign stop    = (ent.stat != S_AOK) || (ent.icode == I_RET);
  // program-load port; memory is deliberately not reset
  always_ff @(posedge clk)
    if (imem_we && imem_waddr < 64'(IMEM_BYTES)) mem[AW'(imem_waddr)] <= imem_wdata;
  // fetch PC, stop flags and FIFO; redirect flushes everything and overrides push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fpc      <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
      halted   <= 1'b0;
      ret_wait <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
      halted   <= 1'b0;
      ret_wait <= 1'b0;
    end else begin
      if (fetch) begin
        q[tail]  <= ent;
        tail     <= tail + 1'b1;
        halted   <= ent.stat != S_AOK;
        ret_wait <= ent.icode == I_RET;
        fpc      <= stop ? fpc : next_pc;
      end
      if (pop) head <= head + 1'b1;
      q_count <= q_count + CW'(fetch) - CW'(pop);
    end
endmodule

// File: tb/tb_y86_fetch_queue.sv
// tb_y86_fetch_queue: scoreboard bench for the fetch queue; expected entries are queued as programs are loaded
module tb_y86_fetch_queue;
  import y86_pkg::*;
  logic        clk, rst_n, imem_we, redirect_valid, d_ready, d_valid;
  logic [63:0] imem_waddr, redirect_pc, d_valC, d_valP, d_pc;
  logic [7:0]  imem_wdata;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
  logic [2:0]  d_stat;
  logic [2:0]  q_count;
  int          n_tests = 0, n_fail = 0;
  fetch_entry_t sb[$];
  fetch_entry_t mon_e;

  y86_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .d_ready(d_ready), .d_valid(d_valid),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP),
    .d_pc(d_pc), .d_stat(d_stat), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [63:0] pc, input logic [3:0] ic, fn, ra, rb,
                                      input logic [63:0] vc, vp, input logic [2:0] st);
    return '{icode: ic, ifun: fn, rA: ra, rB: rb, valC: vc, valP: vp, pc: pc, stat: stat_t'(st)};
  endfunction

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redirect(input logic [63:0] pc);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // scoreboard: every handshake must match the oldest expected entry
  always begin
    @(negedge clk);
    #1;
    if (rst_n && d_valid && d_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("pc", d_pc, mon_e.pc);
        chk("icode", d_icode, mon_e.icode);
        chk("ifun", d_ifun, mon_e.ifun);
        chk("rA", d_rA, mon_e.rA);
        chk("rB", d_rB, mon_e.rB);
        chk("valC", d_valC, mon_e.valC);
        chk("valP", d_valP, mon_e.valP);
        chk("stat", d_stat, mon_e.stat);
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b0;
    // irmovq $4,%rax ; halt
    wr(0, 8'h30); wr(1, 8'hF0);
    for (int i = 2; i < 9; i++) wr(i, 8'h00);
    wr(9, 8'h04); wr(10, 8'h00);
    #1;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_d_pc", d_pc, 0);
    chk("rst_d_stat", d_stat, 0);
    sb.push_back(mk(0, 3, 0, 4'hF, 0, 4, 10, 1));
    sb.push_back(mk(10, 0, 0, 4'hF, 4'hF, 0, 11, 2));
    @(negedge clk);
    rst_n = 1'b1; d_ready = 1'b1;
    cyc(10);
    chk("t1_drained", sb.size(), 0);
    chk("t1_q_count", q_count, 0);
    // 20 nops then halt, decode stalled
    @(negedge clk);
    rst_n = 1'b0; d_ready = 1'b0;
    for (int i = 0; i < 20; i++) wr(i, 8'h10);
    wr(20, 8'h00);
    for (int i = 0; i < 20; i++) sb.push_back(mk(i, 1, 0, 4'hF, 4'hF, 0, i + 1, 1));
    sb.push_back(mk(20, 0, 0, 4'hF, 4'hF, 0, 21, 2));
    rst_n = 1'b1;
    cyc(8);
    #1;
    chk("full_q_count", q_count, 4);
    chk("full_fpc", dut.fpc, 4);
    chk("full_head_pc", d_pc, 0);
    @(negedge clk);
    d_ready = 1'b1;
    cyc(30);
    chk("t2_drained", sb.size(), 0);
    chk("t2_q_count", q_count, 0);
    // reset while full
    @(negedge clk);
    rst_n = 1'b0; d_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    #1;
    chk("t6_full", q_count, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", d_valid, 0);
    chk("t6_rst_count", q_count, 0);
    chk("t6_rst_pc", d_pc, 0);
    chk("t6_rst_icode", d_icode, 0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_first_valid", d_valid, 1);
    chk("t6_first_pc", d_pc, 64'h0);
    chk("t6_first_count", q_count, 1);
    // jmp 0x20
    @(negedge clk);
    rst_n = 1'b0;
    wr(0, 8'h70);
    for (int i = 1; i < 8; i++) wr(i, 8'h00);
    wr(8, 8'h20); wr(9, 8'h00); wr(32, 8'h00);
    sb.push_back(mk(0, 7, 0, 4'hF, 4'hF, 64'h20, 9, 1));
    sb.push_back(mk(64'h20, 0, 0, 4'hF, 4'hF, 0, 64'h21, 2));
    rst_n = 1'b1; d_ready = 1'b1;
    cyc(8);
    chk("jmp_drained", sb.size(), 0);
    // conditional jle 0x20
    @(negedge clk);
    rst_n = 1'b0;
    wr(0, 8'h71);
    sb.push_back(mk(0, 7, 1, 4'hF, 4'hF, 64'h20, 9, 1));
`ifdef FETCH_BRANCH_PREDICT_EN
    sb.push_back(mk(64'h20, 0, 0, 4'hF, 4'hF, 0, 64'h21, 2));
`else
    sb.push_back(mk(9, 0, 0, 4'hF, 4'hF, 0, 10, 2));
`endif
    rst_n = 1'b1;
    cyc(8);
    chk("jcc_drained", sb.size(), 0);
    // ret stops fetch; redirect resumes at 0x30
    @(negedge clk);
    rst_n = 1'b0; d_ready = 1'b0;
    wr(0, 8'h90); wr(64'h30, 8'h00);
    rst_n = 1'b1;
    cyc(6);
    #1;
    chk("ret_count", q_count, 1);
    chk("ret_icode", d_icode, 9);
    chk("ret_pc", d_pc, 0);
    sb.push_back(mk(64'h30, 0, 0, 4'hF, 4'hF, 0, 64'h31, 2));
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h30;
    #1;
    chk("redir_valid_forced", d_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("redir_k1_valid", d_valid, 0);
    @(negedge clk);
    #1;
    chk("redir_k2_valid", d_valid, 1);
    chk("redir_k2_pc", d_pc, 64'h30);
    @(negedge clk);
    d_ready = 1'b1;
    cyc(4);
    chk("redir_drained", sb.size(), 0);
    // ADR at the end of memory, INS, OPq ifun boundary
    wr(2044, 8'h30); wr(2045, 8'hF0); wr(2046, 8'h00); wr(2047, 8'h00);
    wr(64'h40, 8'hC0);
    wr(64'h50, 8'h61); wr(64'h51, 8'h23); wr(64'h52, 8'h64); wr(64'h53, 8'h45);
    sb.push_back(mk(2044, 3, 0, 4'hF, 0, 0, 2054, 3));
    redirect(2044);
    cyc(6);
    chk("adr_drained", sb.size(), 0);
    chk("adr_stopped", q_count, 0);
    sb.push_back(mk(64'h40, 4'hC, 0, 4'hF, 4'hF, 0, 64'h41, 4));
    redirect(64'h40);
    cyc(6);
    chk("ins_drained", sb.size(), 0);
    chk("ins_stopped", q_count, 0);
    sb.push_back(mk(64'h50, 6, 1, 2, 3, 0, 64'h52, 1));
    sb.push_back(mk(64'h52, 6, 4, 4, 5, 0, 64'h54, 4));
    redirect(64'h50);
    cyc(8);
    chk("opq_drained", sb.size(), 0);
    chk("opq_stopped", q_count, 0);
    chk("opq_halted", dut.halted, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
